// File: rtl/adc_seq_pkg.sv
// Shared types and helpers for the ADC capture sequencer.
package adc_seq_pkg;

  localparam int unsigned CHAN_W   = 3;
  localparam int unsigned MAX_CHAN = 1 << CHAN_W;
  localparam int unsigned PICK_W   = CHAN_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_CAPTURE,
    ST_HANDOFF
  } seq_state_t;

  typedef struct packed {
    logic              valid;
    logic [CHAN_W-1:0] idx;
  } chan_pick_t;

  // Lowest set mask bit at or above 'from'; valid=0 when none remain.
  function automatic chan_pick_t next_chan(input logic [MAX_CHAN-1:0] mask,
                                           input logic [PICK_W-1:0]   from);
    chan_pick_t pick;
    pick = '0;
    for (int i = int'(MAX_CHAN) - 1; i >= 0; i--) begin
      if (mask[i] && (PICK_W'(i) >= from)) begin
        pick.valid = 1'b1;
        pick.idx   = CHAN_W'(i);
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/adc_seq_if.sv
// ADC stream inputs and capture-buffer write port of the sequencer.
interface adc_seq_if #(
  parameter int unsigned NCHAN      = 8,
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned DEPTH_LOG2 = 10
);
  logic [NCHAN*DATA_WIDTH-1:0] s_axis_tdata;
  logic [NCHAN-1:0]            s_axis_tvalid;
  logic                        buf_we;
  logic [DEPTH_LOG2-1:0]       buf_addr;
  logic [DATA_WIDTH-1:0]       buf_data;

  modport master (
    input  s_axis_tdata, s_axis_tvalid,
    output buf_we, buf_addr, buf_data
  );

  modport slave (
    output s_axis_tdata, s_axis_tvalid,
    input  buf_we, buf_addr, buf_data
  );
endinterface

// File: rtl/adc_seq_chan_mux.sv
// Registered NCHAN:1 stream select; its register is the buffer write stage.
module adc_seq_chan_mux
  import adc_seq_pkg::*;
#(
  parameter int unsigned NCHAN      = 8,
  parameter int unsigned DATA_WIDTH = 128
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [CHAN_W-1:0]           sel,
  input  logic                        en,
  input  logic [NCHAN*DATA_WIDTH-1:0] tdata,
  input  logic [NCHAN-1:0]            tvalid,
  output logic                        we,
  output logic [DATA_WIDTH-1:0]       data
);

  always_ff @(posedge clk) begin
    if (reset) begin
      we   <= 1'b0;
      data <= '0;
    end else begin
      we <= en & tvalid[sel];
      if (en && tvalid[sel]) begin
        data <= tdata[32'(sel)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: rtl/adc_capture_sequencer.sv
// Steps through masked ADC channels, capturing N beats of each into one
// shared buffer and handing it to the consumer before the next channel.
module adc_capture_sequencer
  import adc_seq_pkg::*;
#(
  parameter int unsigned NCHAN      = 8,
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                aclk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [NCHAN-1:0]    chan_mask,
  input  logic [DEPTH_LOG2:0] nbeats,
  input  logic                sync_sysref,
  input  logic                sysref,
  input  logic                buf_release,
  adc_seq_if.master           bus,
  output logic                chan_ready,
  output logic [CHAN_W-1:0]   chan_id,
  output logic                busy,
  output logic                done,
  output logic                gap,
  output logic                err_mask
);

  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(1) << DEPTH_LOG2;

  seq_state_t            state, state_nxt;
  logic [CHAN_W-1:0]     sel, sel_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [CNT_W-1:0]      n_lat, n_nxt;
  logic [MAX_CHAN-1:0]   mask_lat, mask_nxt;
  logic                  sync_lat, sync_nxt;
  logic                  gap_nxt, err_nxt;
  logic                  sysref_q;
  logic [DEPTH_LOG2-1:0] addr_q;

  logic                  done_c, cap_en_c, accept_c, rise_c, tvalid_sel_c;
  logic [MAX_CHAN-1:0]   mask_in_c;
  logic [CNT_W-1:0]      n_clamp_c;
  chan_pick_t            first_c, next_c;

  assign mask_in_c    = MAX_CHAN'(chan_mask);
  assign n_clamp_c    = ((nbeats == '0) || (nbeats > FULL)) ? FULL : nbeats;
  assign first_c      = next_chan(mask_in_c, PICK_W'(0));
  assign next_c       = next_chan(mask_lat, PICK_W'(sel) + PICK_W'(1));
  assign rise_c       = sysref & ~sysref_q;
  assign tvalid_sel_c = bus.s_axis_tvalid[sel];
  assign accept_c     = cap_en_c & tvalid_sel_c;

  // Sequencing FSM; abort outranks release and beat acceptance.
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    cnt_nxt   = cnt;
    n_nxt     = n_lat;
    mask_nxt  = mask_lat;
    sync_nxt  = sync_lat;
    gap_nxt   = gap;
    err_nxt   = err_mask;
    done_c    = 1'b0;
    cap_en_c  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          gap_nxt = 1'b0;
          err_nxt = ~first_c.valid;
          if (!first_c.valid) begin
            done_c = 1'b1;
          end else begin
            mask_nxt  = mask_in_c;
            n_nxt     = n_clamp_c;
            sync_nxt  = sync_sysref;
            sel_nxt   = first_c.idx;
            cnt_nxt   = '0;
            state_nxt = ST_SYNC;
          end
        end
      end
      ST_SYNC: begin
        if (abort) begin
          done_c    = 1'b1;
          state_nxt = ST_IDLE;
        end else if (!sync_lat || rise_c) begin
          cnt_nxt   = '0;
          state_nxt = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (abort) begin
          done_c    = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          cap_en_c = 1'b1;
          if (tvalid_sel_c) begin
            if (cnt == (n_lat - CNT_W'(1))) begin
              state_nxt = ST_HANDOFF;
            end else begin
              cnt_nxt = cnt + CNT_W'(1);
            end
          end else begin
            gap_nxt = 1'b1;
          end
        end
      end
      ST_HANDOFF: begin
        if (abort) begin
          done_c    = 1'b1;
          state_nxt = ST_IDLE;
        end else if (buf_release) begin
          if (next_c.valid) begin
            sel_nxt   = next_c.idx;
            state_nxt = ST_SYNC;
          end else begin
            done_c    = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // sysref_q samples every cycle so edge detection spans all states.
  always_ff @(posedge aclk) begin
    if (reset) begin
      state      <= ST_IDLE;
      sel        <= '0;
      cnt        <= '0;
      n_lat      <= '0;
      mask_lat   <= '0;
      sync_lat   <= 1'b0;
      sysref_q   <= 1'b0;
      addr_q     <= '0;
      gap        <= 1'b0;
      err_mask   <= 1'b0;
      busy       <= 1'b0;
      chan_ready <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      sel        <= sel_nxt;
      cnt        <= cnt_nxt;
      n_lat      <= n_nxt;
      mask_lat   <= mask_nxt;
      sync_lat   <= sync_nxt;
      sysref_q   <= sysref;
      gap        <= gap_nxt;
      err_mask   <= err_nxt;
      busy       <= (state_nxt != ST_IDLE);
      chan_ready <= (state_nxt == ST_HANDOFF);
      done       <= done_c;
      if (accept_c) begin
        addr_q <= cnt[DEPTH_LOG2-1:0];
      end
    end
  end

  assign chan_id      = sel;
  assign bus.buf_addr = addr_q;

  adc_seq_chan_mux #(
    .NCHAN      (NCHAN),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mux (
    .clk    (aclk),
    .reset  (reset),
    .sel    (sel),
    .en     (cap_en_c),
    .tdata  (bus.s_axis_tdata),
    .tvalid (bus.s_axis_tvalid),
    .we     (bus.buf_we),
    .data   (bus.buf_data)
  );

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Directed bench for adc_capture_sequencer; writes are logged at negedge.
module tb_adc_capture_sequencer;
  import adc_seq_pkg::*;

  localparam int unsigned NCHAN = 8;
  localparam int unsigned DW    = 32;
  localparam int unsigned DL    = 4;

  logic          aclk = 1'b0;
  logic          reset, start, abort, sync_sysref, sysref, buf_release;
  logic [7:0]    chan_mask;
  logic [DL:0]   nbeats;
  logic          chan_ready, busy, done, gap, err_mask;
  logic [2:0]    chan_id;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int wr_addr[$];
  int wr_ch[$];
  int wr_cyc[$];

  adc_seq_if #(.NCHAN(NCHAN), .DATA_WIDTH(DW), .DEPTH_LOG2(DL)) bus ();

  adc_capture_sequencer #(.NCHAN(NCHAN), .DATA_WIDTH(DW), .DEPTH_LOG2(DL)) dut (
    .aclk(aclk), .reset(reset), .start(start), .abort(abort),
    .chan_mask(chan_mask), .nbeats(nbeats), .sync_sysref(sync_sysref),
    .sysref(sysref), .buf_release(buf_release), .bus(bus),
    .chan_ready(chan_ready), .chan_id(chan_id), .busy(busy), .done(done),
    .gap(gap), .err_mask(err_mask)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  always @(negedge aclk) begin
    if (bus.buf_we === 1'b1) begin
      wr_addr.push_back(int'(bus.buf_addr));
      wr_ch.push_back(int'(bus.buf_data[31:24]) - 'hA0);
      wr_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic settle();
    @(negedge aclk);
    #1;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_ch.delete();
    wr_cyc.delete();
  endtask

  task automatic wait_ready(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (chan_ready === 1'b1) ok = 1'b1;
    end
    if (ok) settle();
  endtask

  task automatic launch(input logic [7:0] m, input logic [DL:0] n, input logic s, output int at);
    chan_mask = m; nbeats = n; sync_sysref = s; start = 1'b1;
    at = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    settle();
    checks++;
    if ({busy, done, chan_ready, gap, err_mask, bus.buf_we} !== 6'b0)
      $display("FAIL reset_flags got %b want 000000", {busy, done, chan_ready, gap, err_mask, bus.buf_we});
    checks++;
    if (chan_id !== 3'd0) begin errors++; $display("FAIL reset_chan_id got %0d want 0", chan_id); end
    checks++;
    if (bus.buf_addr !== '0 || bus.buf_data !== '0) begin
      errors++; $display("FAIL reset_buf got %h/%h want 0/0", bus.buf_addr, bus.buf_data);
    end
    if ({busy, done, chan_ready, gap, err_mask, bus.buf_we} !== 6'b0) errors++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int s; bit ok; int n1;
    clear_log();
    bus.s_axis_tvalid = '1;
    launch(8'h05, 5'd4, 1'b0, s);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", busy); end
    wait_ready(40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_ready0 got timeout want chan_ready"); end
    checks++;
    if (wr_addr.size() != 4) begin errors++; $display("FAIL basic_cnt0 got %0d want 4", wr_addr.size()); end
    for (int i = 0; i < wr_addr.size(); i++) begin
      checks++;
      if (wr_addr[i] != i || wr_ch[i] != 0) begin
        errors++; $display("FAIL basic_wr0[%0d] got addr %0d ch %0d want addr %0d ch 0", i, wr_addr[i], wr_ch[i], i);
      end
    end
    checks++;
    if (wr_cyc.size() == 0 || wr_cyc[0] != s + 3) begin
      errors++; $display("FAIL basic_first_wr got cyc %0d want %0d", (wr_cyc.size() == 0) ? -1 : wr_cyc[0], s + 3);
    end
    checks++;
    if (chan_id !== 3'd0 || gap !== 1'b0) begin errors++; $display("FAIL basic_id0 got id %0d gap %b want 0 0", chan_id, gap); end
    buf_release = 1'b1; tick(); buf_release = 1'b0;
    checks++;
    if (chan_ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL basic_rel0 got ready %b busy %b done %b want 0 1 0", chan_ready, busy, done);
    end
    wait_ready(40, ok);
    checks++;
    if (!ok || wr_addr.size() != 8) begin errors++; $display("FAIL basic_cnt2 got %0d want 8", wr_addr.size()); end
    for (int i = 4; i < wr_addr.size(); i++) begin
      checks++;
      if (wr_addr[i] != i - 4 || wr_ch[i] != 2) begin
        errors++; $display("FAIL basic_wr2[%0d] got addr %0d ch %0d want addr %0d ch 2", i, wr_addr[i], wr_ch[i], i - 4);
      end
    end
    checks++;
    if (chan_id !== 3'd2) begin errors++; $display("FAIL basic_id2 got %0d want 2", chan_id); end
    buf_release = 1'b1; tick(); buf_release = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || chan_ready !== 1'b0) begin
      errors++; $display("FAIL basic_done got done %b busy %b ready %b want 1 0 0", done, busy, chan_ready);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", done); end
    n1 = 0;
    foreach (wr_ch[i]) if (wr_ch[i] == 1) n1++;
    checks++;
    if (n1 != 0) begin errors++; $display("FAIL basic_ch1 got %0d writes want 0", n1); end
  endtask

  task automatic test_sync();
    int s; int e; bit ok;
    clear_log();
    bus.s_axis_tvalid = '1;
    sysref = 1'b0;
    launch(8'h02, 5'd3, 1'b1, s);
    while (cyc < s + 37) tick();
    settle();
    checks++;
    if (wr_addr.size() != 0 || busy !== 1'b1) begin
      errors++; $display("FAIL sync_hold got %0d writes busy %b want 0 1", wr_addr.size(), busy);
    end
    sysref = 1'b1;
    e = cyc;
    wait_ready(20, ok);
    sysref = 1'b0;
    checks++;
    if (!ok || wr_addr.size() != 3) begin errors++; $display("FAIL sync_cnt got %0d want 3", wr_addr.size()); end
    checks++;
    if (wr_cyc.size() == 0 || wr_cyc[0] != e + 2) begin
      errors++; $display("FAIL sync_first_wr got cyc %0d want %0d", (wr_cyc.size() == 0) ? -1 : wr_cyc[0], e + 2);
    end
    checks++;
    if (chan_id !== 3'd1) begin errors++; $display("FAIL sync_id got %0d want 1", chan_id); end
    buf_release = 1'b1; tick(); buf_release = 1'b0;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL sync_done got %b want 1", done); end
    sync_sysref = 1'b0;
  endtask

  task automatic test_gap();
    int s;
    bit pat [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    clear_log();
    bus.s_axis_tvalid = '0;
    launch(8'h08, 5'd4, 1'b0, s);
    tick();
    foreach (pat[i]) begin
      bus.s_axis_tvalid[3] = pat[i];
      tick();
    end
    bus.s_axis_tvalid = '0;
    settle();
    checks++;
    if (chan_ready !== 1'b1 || gap !== 1'b1 || chan_id !== 3'd3) begin
      errors++; $display("FAIL gap_state got ready %b gap %b id %0d want 1 1 3", chan_ready, gap, chan_id);
    end
    checks++;
    if (wr_addr.size() != 4) begin errors++; $display("FAIL gap_cnt got %0d want 4", wr_addr.size()); end
    for (int i = 0; i < wr_addr.size(); i++) begin
      checks++;
      if (wr_addr[i] != i || wr_ch[i] != 3) begin
        errors++; $display("FAIL gap_wr[%0d] got addr %0d ch %0d want addr %0d ch 3", i, wr_addr[i], wr_ch[i], i);
      end
    end
    buf_release = 1'b1; tick(); buf_release = 1'b0;
    checks++;
    if (done !== 1'b1 || gap !== 1'b1) begin errors++; $display("FAIL gap_done got done %b gap %b want 1 1", done, gap); end
  endtask

  task automatic test_clamp();
    int s; bit ok;
    logic [DL:0] nv [2] = '{5'd0, 5'd17};
    bus.s_axis_tvalid = '1;
    foreach (nv[k]) begin
      clear_log();
      launch(8'h01, nv[k], 1'b0, s);
      wait_ready(60, ok);
      checks++;
      if (!ok || wr_addr.size() != 16) begin
        errors++; $display("FAIL clamp_cnt n=%0d got %0d want 16", nv[k], wr_addr.size());
      end
      checks++;
      if (wr_addr.size() == 0 || wr_addr[wr_addr.size()-1] != 15) begin
        errors++; $display("FAIL clamp_last n=%0d got %0d want 15", nv[k], (wr_addr.size() == 0) ? -1 : wr_addr[wr_addr.size()-1]);
      end
      buf_release = 1'b1; tick(); buf_release = 1'b0;
      checks++;
      if (done !== 1'b1) begin errors++; $display("FAIL clamp_done n=%0d got %b want 1", nv[k], done); end
    end
  endtask

  task automatic test_abort();
    int s; bit ok;
    clear_log();
    bus.s_axis_tvalid = '1;
    launch(8'h03, 5'd8, 1'b0, s);
    tick(); tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || chan_ready !== 1'b0) begin
      errors++; $display("FAIL abort_state got done %b busy %b ready %b want 1 0 0", done, busy, chan_ready);
    end
    tick(); tick(); tick();
    settle();
    checks++;
    if (wr_addr.size() != 2) begin errors++; $display("FAIL abort_cnt got %0d want 2", wr_addr.size()); end
    for (int i = 0; i < wr_addr.size(); i++) begin
      checks++;
      if (wr_addr[i] != i) begin errors++; $display("FAIL abort_wr[%0d] got %0d want %0d", i, wr_addr[i], i); end
    end
    clear_log();
    launch(8'h01, 5'd4, 1'b0, s);
    wait_ready(40, ok);
    checks++;
    if (!ok || wr_addr.size() != 4 || chan_id !== 3'd0) begin
      errors++; $display("FAIL abort_restart got %0d writes id %0d want 4 0", wr_addr.size(), chan_id);
    end
    buf_release = 1'b1; tick(); buf_release = 1'b0;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL abort_restart_done got %b want 1", done); end
  endtask

  task automatic test_mask0_and_busy_start();
    int s; bit ok;
    clear_log();
    launch(8'h00, 5'd4, 1'b0, s);
    checks++;
    if (err_mask !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL mask0 got err %b done %b busy %b want 1 1 0", err_mask, done, busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || err_mask !== 1'b1) begin
      errors++; $display("FAIL mask0_after got busy %b done %b err %b want 0 0 1", busy, done, err_mask);
    end
    launch(8'h01, 5'd2, 1'b0, s);
    checks++;
    if (err_mask !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL err_clear got err %b busy %b want 0 1", err_mask, busy);
    end
    wait_ready(20, ok);
    launch(8'hFF, 5'd4, 1'b0, s);
    tick();
    settle();
    checks++;
    if (!ok || chan_ready !== 1'b1 || chan_id !== 3'd0 || busy !== 1'b1 || wr_addr.size() != 2) begin
      errors++; $display("FAIL busy_start got ready %b id %0d busy %b writes %0d want 1 0 1 2",
                         chan_ready, chan_id, busy, wr_addr.size());
    end
    buf_release = 1'b1; tick(); buf_release = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL busy_start_done got done %b busy %b want 1 0", done, busy);
    end
    launch(8'h00, 5'd1, 1'b0, s);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; sync_sysref = 1'b0; sysref = 1'b0;
    buf_release = 1'b0; chan_mask = '0; nbeats = '0;
    bus.s_axis_tvalid = '0;
    for (int k = 0; k < int'(NCHAN); k++)
      bus.s_axis_tdata[k*DW +: DW] = {8'(32'hA0 + k), 24'h00F00D};
    test_reset();
    test_basic();
    test_sync();
    test_gap();
    test_reset();
    test_clamp();
    test_abort();
    test_mask0_and_busy_start();
    test_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
